// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator.
// Decodes one word per cycle into a 2-entry output queue.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam bit RV64 = (XLEN == 64);
    localparam int SHW  = RV64 ? 6 : 5;

    typedef enum logic [2:0] {
        F_R = 3'd0,
        F_I = 3'd1,
        F_S = 3'd2,
        F_B = 3'd3,
        F_U = 3'd4,
        F_J = 3'd5,
        F_X = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            ill;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;
    fmt_e       dfmt;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // slli/srli/srai carry a shamt, not a signed immediate
    assign is_shift = (opcode == 7'b0010011) && (funct3[1:0] == 2'b01);

    always_comb begin
        dfmt = F_X;
        case (opcode)
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011: dfmt = F_I;
            7'b0011011: dfmt = RV64 ? F_I : F_X;
            7'b0100011: dfmt = F_S;
            7'b1100011: dfmt = F_B;
            7'b0110111,
            7'b0010111: dfmt = F_U;
            7'b1101111: dfmt = F_J;
            7'b0110011: dfmt = F_R;
            7'b0111011: dfmt = RV64 ? F_R : F_X;
            default:    dfmt = F_X;
        endcase
    end

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;
    logic [XLEN-1:0]    shamt;
    logic [XLEN-1:0]    dimm;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25],
                    inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20],
                    inst[30:21], 1'b0};
    assign shamt = XLEN'(inst[19+SHW:20]);

    // signed 32-bit values sign-extend through the XLEN cast
    always_comb begin
        dimm = '0;
        case (dfmt)
            F_I:     dimm = is_shift ? shamt : XLEN'(imm_i);
            F_S:     dimm = XLEN'(imm_s);
            F_B:     dimm = XLEN'(imm_b);
            F_U:     dimm = XLEN'(imm_u);
            F_J:     dimm = XLEN'(imm_j);
            default: dimm = '0;
        endcase
    end

    entry_t     din;
    entry_t     head;
    entry_t     q [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign din.imm = dimm;
    assign din.fmt = dfmt;
    assign din.ill = (dfmt == F_X);

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            q[0]          <= '0;
            q[1]          <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= 2'd0;
            illegal_count <= '0;
        end else begin
            if (push) begin
                q[wr_ptr] <= din;
                wr_ptr    <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push && din.ill && (illegal_count != '1)) begin
                illegal_count <= illegal_count + CNT_W'(1);
            end
        end
    end

    assign head    = q[rd_ptr];
    assign imm     = head.imm;
    assign fmt     = head.fmt;
    assign illegal = head.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance in lockstep
// and scoreboards both against an arithmetic reference decoder.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;

    logic        ir32, ov32, il32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [15:0] cnt32;

    logic        ir64, ov64, il64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [2:0]  cnt64;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ir32), .inst(inst),
        .out_valid(ov32), .out_ready(out_ready),
        .imm(imm32), .fmt(fmt32), .illegal(il32),
        .illegal_count(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(3)) u64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ir64), .inst(inst),
        .out_valid(ov64), .out_ready(out_ready),
        .imm(imm64), .fmt(fmt64), .illegal(il64),
        .illegal_count(cnt64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          ecnt[2];
    bit          rchk[2];
    bit          hold[2];
    logic [63:0] last_imm[2];
    logic [2:0]  last_fmt[2];

    task automatic chk(input string nm, input int s,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[x%0d]: got %h, expected %h",
                     nm, s == 0 ? 32 : 64, act, exp);
        end
    endtask

    function automatic int sb_size(input int s);
        return s == 0 ? sb0.size() : sb1.size();
    endfunction

    function automatic longint sx(input longint v, input int bits);
        longint h = longint'(1) << (bits - 1);
        return (v >= h) ? v - (h << 1) : v;
    endfunction

    // reference decoder: opcode lookup plus field arithmetic
    function automatic exp_t model(input logic [31:0] w, input int xlen);
        exp_t   e;
        longint v = longint'(w);
        longint r = 0;
        int     op = int'(v & 'h7f);
        int     f3 = int'((v >> 12) & 7);
        int     f;
        bit     rv64 = (xlen == 64);
        if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
            f = 1; r = (v >> 20) & (rv64 ? 63 : 31);
        end else if (op == 'h13 || op == 'h03 || op == 'h67 ||
                     op == 'h73 || (rv64 && op == 'h1b)) begin
            f = 1; r = sx(v >> 20, 12);
        end else if (op == 'h23) begin
            f = 2; r = sx(((v >> 25) << 5) + ((v >> 7) & 31), 12);
        end else if (op == 'h63) begin
            f = 3;
            r = sx(((v >> 31) & 1) * 4096 + ((v >> 7) & 1) * 2048 +
                   ((v >> 25) & 63) * 32 + ((v >> 8) & 15) * 2, 13);
        end else if (op == 'h37 || op == 'h17) begin
            f = 4; r = sx(v & 'hfffff000, 32);
        end else if (op == 'h6f) begin
            f = 5;
            r = sx(((v >> 31) & 1) * (1 << 20) +
                   ((v >> 12) & 255) * 4096 +
                   ((v >> 20) & 1) * 2048 +
                   ((v >> 21) & 1023) * 2, 21);
        end else if (op == 'h33 || (rv64 && op == 'h3b)) begin
            f = 0; r = 0;
        end else begin
            f = 7; r = 0;
        end
        e.imm = (xlen == 32) ? (r & 64'hffffffff) : r;
        e.fmt = 3'(f);
        e.ill = (f == 7);
        return e;
    endfunction

    task automatic side(input int s, input logic ov, input logic ir,
                        input logic [63:0] im, input logic [2:0] f,
                        input logic il, input int cnt, input int cmax,
                        input int xlen);
        exp_t e;
        if (reset) begin
            if (s == 0) sb0.delete(); else sb1.delete();
            ecnt[s] = 0;
            rchk[s] = 1;
            hold[s] = 0;
            return;
        end
        if (rchk[s]) begin
            chk("rst_imm", s, im, 0);
            chk("rst_fmt", s, f, 0);
            chk("rst_illegal", s, il, 0);
            rchk[s] = 0;
        end
        chk("out_valid", s, ov, sb_size(s) != 0);
        chk("in_ready", s, ir, sb_size(s) < 2);
        chk("illegal_count", s, cnt, ecnt[s]);
        if (hold[s]) begin
            chk("hold_imm", s, im, last_imm[s]);
            chk("hold_fmt", s, f, last_fmt[s]);
        end
        if (ov && sb_size(s) > 0) begin
            e = (s == 0) ? sb0[0] : sb1[0];
            chk("imm", s, im, e.imm);
            chk("fmt", s, f, e.fmt);
            chk("illegal", s, il, e.ill);
            if (out_ready) begin
                if (s == 0) void'(sb0.pop_front());
                else        void'(sb1.pop_front());
            end
        end
        hold[s]     = ov && !out_ready;
        last_imm[s] = im;
        last_fmt[s] = f;
        if (in_valid && ir) begin
            e = model(inst, xlen);
            if (s == 0) sb0.push_back(e); else sb1.push_back(e);
            if (e.ill && ecnt[s] < cmax) ecnt[s]++;
        end
    endtask

    always @(negedge clk) begin
        side(0, ov32, ir32, {32'b0, imm32}, fmt32, il32,
             int'(cnt32), 65535, 32);
        side(1, ov64, ir64, imm64, fmt64, il64,
             int'(cnt64), 7, 64);
    end

    task automatic send(input logic [31:0] w);
        bit ok = 0;
        inst     = w;
        in_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = ir32;
            @(posedge clk);
            #1;
        end
        chk("send_accept", 0, ok, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] dir [11] = '{
        32'h00100093, 32'h001121A3, 32'hFE000EE3, 32'h0010006F,
        32'hFFF00093, 32'h800000B7, 32'h03F09093, 32'h4030D093,
        32'h00000000, 32'h0000007F, 32'h00100093
    };

    logic [6:0] ops [12] = '{
        7'h13, 7'h03, 7'h67, 7'h73, 7'h1b, 7'h23,
        7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h3b
    };

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        int          k = $urandom_range(0, 12);
        if (k < 12) w[6:0] = ops[k];
        return w;
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        inst      = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        foreach (dir[i]) send(dir[i]);
        idle(3);

        out_ready = 1'b0;
        send(32'h00500113);
        send(32'h00C0006F);
        inst     = 32'h12345037;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h12345037);
        idle(3);

        out_ready = 1'b0;
        send(32'hFFF10113);
        out_ready = 1'b1;
        send(32'h00208463);
        idle(3);

        for (int i = 0; i < 10; i++) send(32'h00000000 + i);
        send(32'h00100093);
        idle(3);

        out_ready = 1'b0;
        send(32'h00000013);
        send(32'h0000007F);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        send(32'h001121A3);
        idle(3);

        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            inst      = rand_inst();
            @(posedge clk);
            #1;
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (sb_size(0) + sb_size(1) == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 0, sb_size(0) + sb_size(1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, flow-controlled RISC-V immediate generator for RV32I/RV64I, parametrised on XLEN. It accepts one instruction word per cycle through a valid/ready handshake. Each word is classified into an instruction format and produces a sign-extended immediate. Results pass through a 2-entry output queue, so decode back-pressure never corrupts results. The block sits between fetch and decode and replaces the combinational immediate generator in the pipelined core.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets immediate width and shamt width (5 bits at 32, 6 bits at 64).
CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high; clears all state.
in_valid  input  1  inst is valid this cycle.
in_ready  output  1  block can accept inst this cycle.
inst  input  32  instruction word.
out_valid  output  1  head of queue is valid.
out_ready  input  1  consumer accepts head this cycle.
imm  output  XLEN  immediate of head entry.
fmt  output  3  format of head entry: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
illegal  output  1  head entry is unrecognised.
illegal_count  output  CNT_W  saturating count of accepted illegal words.

Behaviour:
- Decode is on opcode inst[6:0]:
  - I: 0010011, 0000011, 1100111, 1110011; also 0011011 when XLEN=64.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - R: 0110011; also 0111011 when XLEN=64.
  - Anything else, including inst[1:0]!=11: illegal.
- Immediates, sign-extended from inst[31] to XLEN:
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'b0}, then sign-extended to XLEN.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R: imm=0.
- Shift-immediates (opcode 0010011 with funct3 001 or 101): imm = zero-extended shamt, i.e. inst[24:20] at XLEN=32 or inst[25:20] at XLEN=64. funct7 bits are stripped.
- Illegal word: imm=0, fmt=7, illegal=1. It is still enqueued and delivered in order.
- Queue: 2-entry FIFO with a registered occupancy count (0..2).
  - in_ready = (count != 2). It depends only on registered state, never on out_ready.
  - out_valid = (count != 0). imm/fmt/illegal always show the head entry.
  - Enqueue on in_valid && in_ready. Dequeue on out_valid && out_ready.
  - Simultaneous enqueue and dequeue: count unchanged, order preserved.
  - Full with dequeue: no enqueue that cycle (in_ready was 0); count goes to 1.
  - Empty: out_valid=0, and no bypass.
- Latency: a word accepted at edge N is visible with out_valid=1 after edge N, provided the queue was empty. Sustained throughput is 1 word/cycle when out_ready is held high.
- Outputs are held stable while out_valid && !out_ready.
- illegal_count increments once per accepted illegal word and saturates at 2^CNT_W-1.
- Reset (including mid-transfer), at the next edge:
  - count=0, out_valid=0, in_ready=1.
  - imm=0, fmt=0, illegal=0, illegal_count=0.
  - Queued entries are discarded.

Test Plan:
- XLEN=32, out_ready=1. Stream 0x00100093 (addi), 0x001121A3 (sw), 0xFE000EE3 (beq -4), 0x0010006F (jal +2048) -> imm 0x00000001 (fmt 1), 0x00000003 (fmt 2), 0xFFFFFFFC (fmt 3), 0x00000800 (fmt 5). Each appears one cycle after acceptance, back-to-back.
- XLEN=64. Words 0xFFF00093, 0x800000B7 (lui), 0x03F09093 (slli 63), 0x4030D093 (srai 3) -> imm 0xFFFFFFFFFFFFFFFF, 0xFFFFFFFF80000000, 0x000000000000003F, 0x0000000000000003.
- Illegal words 0x00000000 and 0x0000007F -> illegal=1, fmt=7, imm=0, illegal_count 0 -> 1 -> 2. Following legal word 0x00100093 decodes normally.
- Back-pressure: out_ready=0, offer 3 words -> two accepted, in_ready=0 on the third and outputs stable. Raise out_ready -> words emerge in order, third accepted on the first dequeue cycle.
- Simultaneous: count=1, in_valid=1 and out_ready=1 -> count stays 1, order intact.
- Assert reset with 2 entries queued -> out_valid=0, in_ready=1, illegal_count=0 next cycle. A word sent after reset is delivered alone.
